// File: rtl/dmem_arbiter_if.sv
// Bundle between the two requesters, the arbiter and the data memory.
// Signal names match the arbiter's external pin names.
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              rvalid0, rvalid1;
    logic              err0, err1;
    logic [ADDR_W-1:0] data_address;
    logic [DATA_W-1:0] write_data;
    logic              MemRead, MemWrite;
    logic [DATA_W-1:0] read_data;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
        output gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err0, err1,
               data_address, write_data, MemRead, MemWrite, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, read_data,
        input  gnt0, gnt1, rdata0, rdata1, rvalid0, rvalid1, err0, err1,
               data_address, write_data, MemRead, MemWrite, busy
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: latches one request per IDLE cycle, issues it
// to a single-cycle-latency memory, and returns registered read data.
module dmem_arbiter #(
    parameter int unsigned RR_EN  = 1,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RESP, ERR} state_e;

    state_e            state_q, state_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              last_q, last_d;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic              rvalid0_q, rvalid1_q;
    logic              gnt0, gnt1, err0, err1, mem_read, mem_write;

    always_comb begin
        // NOTE: every combinational output is defaulted first so no branch can infer a latch.
        state_d   = state_q;
        port_d    = port_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_d    = last_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        err0      = 1'b0;
        err1      = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // Contention goes to the port that did not win last time, or always port 0.
                    if (bus.req0 && bus.req1) port_d = (RR_EN != 0) ? ~last_q : 1'b0;
                    else                      port_d = bus.req1;
                    last_d  = port_d;
                    we_d    = port_d ? bus.we1    : bus.we0;
                    addr_d  = port_d ? bus.addr1  : bus.addr0;
                    wdata_d = port_d ? bus.wdata1 : bus.wdata0;
                    state_d = (addr_d[1:0] != 2'b00) ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                gnt0      = ~port_q;
                gnt1      = port_q;
                mem_read  = ~we_q;
                mem_write = we_q;
                state_d   = we_q ? IDLE : RESP;
            end
            RESP: state_d = IDLE;
            ERR: begin
                gnt0    = ~port_q;
                gnt1    = port_q;
                err0    = ~port_q;
                err1    = port_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= IDLE;
            port_q    <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            last_q    <= 1'b1;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            port_q    <= port_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            last_q    <= last_d;
            rvalid0_q <= (state_q == RESP) && !port_q;
            rvalid1_q <= (state_q == RESP) &&  port_q;
            if ((state_q == RESP) && !port_q) rdata0_q <= bus.read_data;
            if ((state_q == RESP) &&  port_q) rdata1_q <= bus.read_data;
        end
    end

    assign bus.gnt0         = gnt0;
    assign bus.gnt1         = gnt1;
    assign bus.err0         = err0;
    assign bus.err1         = err1;
    assign bus.rvalid0      = rvalid0_q;
    assign bus.rvalid1      = rvalid1_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.MemRead      = mem_read;
    assign bus.MemWrite     = mem_write;
    assign bus.data_address = addr_q;
    assign bus.write_data   = wdata_q;
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance backed by a small
// memory model, plus a fixed-priority instance used for the contention case.
module tb_dmem_arbiter;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) rr_if ();
    dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) fp_if ();

    dmem_arbiter #(.RR_EN(1), .ADDR_W(32), .DATA_W(32)) u_rr (.clk(clk), .rst(rst), .bus(rr_if));
    dmem_arbiter #(.RR_EN(0), .ADDR_W(32), .DATA_W(32)) u_fp (.clk(clk), .rst(rst), .bus(fp_if));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory with one cycle of read latency, word-indexed by addr[5:2].
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (rr_if.MemWrite) mem[rr_if.data_address[5:2]] <= rr_if.write_data;
        if (rr_if.MemRead)  rr_if.read_data <= mem[rr_if.data_address[5:2]];
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required normal completion");
        $fatal(1, "watchdog");
    end

    // {busy, MemWrite, MemRead, gnt1, gnt0, err1, err0, rvalid1, rvalid0}
    function automatic logic [8:0] rr_st();
        return {rr_if.busy, rr_if.MemWrite, rr_if.MemRead, rr_if.gnt1, rr_if.gnt0,
                rr_if.err1, rr_if.err0, rr_if.rvalid1, rr_if.rvalid0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        rr_if.req0 = 0; rr_if.req1 = 0; rr_if.we0 = 0; rr_if.we1 = 0;
        rr_if.addr0 = '0; rr_if.addr1 = '0; rr_if.wdata0 = '0; rr_if.wdata1 = '0;
        fp_if.req0 = 0; fp_if.req1 = 0; fp_if.we0 = 0; fp_if.we1 = 0;
        fp_if.addr0 = '0; fp_if.addr1 = '0; fp_if.wdata0 = '0; fp_if.wdata1 = '0;
        fp_if.read_data = 32'hCAFE_F00D;
    endtask

    task automatic test_reset();
        logic [8:0] exp;
        rst = 1'b1;
        tick();
        tick();
        exp = 9'b0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL reset_status: got %b required %b", rr_st(), exp);
        end
        n_cmp++;
        if ({rr_if.data_address, rr_if.write_data, rr_if.rdata0, rr_if.rdata1} !== 128'h0) begin
            n_err++; $display("FAIL reset_data: got %h %h %h %h required all 0",
                              rr_if.data_address, rr_if.write_data, rr_if.rdata0, rr_if.rdata1);
        end
        rst = 1'b0;
    endtask

    task automatic test_write();
        logic [8:0] exp;
        rr_if.req0 = 1; rr_if.we0 = 1; rr_if.addr0 = 32'h10; rr_if.wdata0 = 32'h4;
        tick();
        exp = 9'b1_1_0_0_1_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL write_issue: got %b required %b", rr_st(), exp);
        end
        n_cmp++;
        if ({rr_if.data_address, rr_if.write_data} !== {32'h10, 32'h4}) begin
            n_err++; $display("FAIL write_bus: got %h/%h required 10/4", rr_if.data_address, rr_if.write_data);
        end
        rr_if.req0 = 0;
        tick();
        exp = 9'b0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL write_done: got %b required %b", rr_st(), exp);
        end
        n_cmp++;
        if (rr_if.data_address !== 32'h10) begin
            n_err++; $display("FAIL write_addr_hold: got %h required 10", rr_if.data_address);
        end
        rr_if.req1 = 1; rr_if.we1 = 1; rr_if.addr1 = 32'h14; rr_if.wdata1 = 32'hA5A5;
        tick();
        exp = 9'b1_1_0_1_0_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL write1_issue: got %b required %b", rr_st(), exp);
        end
        rr_if.req1 = 0;
        tick();
    endtask

    task automatic test_read();
        logic [8:0] exp;
        rr_if.req1 = 1; rr_if.we1 = 0; rr_if.addr1 = 32'h10;
        tick();
        exp = 9'b1_0_1_1_0_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL read_issue: got %b required %b", rr_st(), exp);
        end
        rr_if.req1 = 0;
        tick();
        exp = 9'b1_0_0_0_0_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL read_resp: got %b required %b", rr_st(), exp);
        end
        tick();
        exp = 9'b0_0_0_0_0_0_0_1_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL read_rvalid: got %b required %b", rr_st(), exp);
        end
        n_cmp++;
        if ({rr_if.rdata1, rr_if.rdata0} !== {32'h4, 32'h0}) begin
            n_err++; $display("FAIL read_data: got rdata1=%h rdata0=%h required 4/0", rr_if.rdata1, rr_if.rdata0);
        end
        tick();
        n_cmp++;
        if ({rr_if.rvalid1, rr_if.rdata1} !== {1'b0, 32'h4}) begin
            n_err++; $display("FAIL read_after: got rvalid1=%b rdata1=%h required 0/4", rr_if.rvalid1, rr_if.rdata1);
        end
    endtask

    task automatic test_contention();
        logic [1:0] rr_g [10] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        logic [1:0] rr_v [10] = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01};
        logic [1:0] fp_g [10] = '{2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rr_if.req0 = 1; rr_if.we0 = 0; rr_if.addr0 = 32'h10;
        rr_if.req1 = 1; rr_if.we1 = 0; rr_if.addr1 = 32'h14;
        fp_if.req0 = 1; fp_if.we0 = 0; fp_if.addr0 = 32'h0;
        fp_if.req1 = 1; fp_if.we1 = 0; fp_if.addr1 = 32'h4;
        for (int i = 1; i <= 9; i++) begin
            tick();
            n_cmp++;
            if ({rr_if.gnt1, rr_if.gnt0} !== rr_g[i]) begin
                n_err++; $display("FAIL rr_gnt cycle %0d: got %b required %b", i, {rr_if.gnt1, rr_if.gnt0}, rr_g[i]);
            end
            n_cmp++;
            if ({rr_if.rvalid1, rr_if.rvalid0} !== rr_v[i]) begin
                n_err++; $display("FAIL rr_rvalid cycle %0d: got %b required %b", i, {rr_if.rvalid1, rr_if.rvalid0}, rr_v[i]);
            end
            n_cmp++;
            if ({fp_if.gnt1, fp_if.gnt0} !== fp_g[i]) begin
                n_err++; $display("FAIL fp_gnt cycle %0d: got %b required %b", i, {fp_if.gnt1, fp_if.gnt0}, fp_g[i]);
            end
            if (i == 3) begin
                n_cmp++;
                if (rr_if.rdata0 !== 32'h4) begin
                    n_err++; $display("FAIL rr_rdata0: got %h required 4", rr_if.rdata0);
                end
                n_cmp++;
                if (fp_if.rdata0 !== 32'hCAFE_F00D) begin
                    n_err++; $display("FAIL fp_rdata0: got %h required cafef00d", fp_if.rdata0);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (rr_if.rdata1 !== 32'hA5A5) begin
                    n_err++; $display("FAIL rr_rdata1: got %h required a5a5", rr_if.rdata1);
                end
            end
            if (i == 7) idle_inputs();
        end
    endtask

    task automatic test_misaligned();
        logic [8:0] exp;
        rr_if.req0 = 1; rr_if.we0 = 0; rr_if.addr0 = 32'h6;
        tick();
        exp = 9'b1_0_0_0_1_0_1_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL misaligned0: got %b required %b", rr_st(), exp);
        end
        rr_if.req0 = 0;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if (rr_st() !== 9'b0) begin
                n_err++; $display("FAIL misaligned0_after %0d: got %b required 000000000", i, rr_st());
            end
        end
        rr_if.req1 = 1; rr_if.we1 = 1; rr_if.addr1 = 32'h13;
        tick();
        exp = 9'b1_0_0_1_0_1_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL misaligned1: got %b required %b", rr_st(), exp);
        end
        rr_if.req1 = 0;
        tick();
    endtask

    // The port-1 error latch just above makes port 0 the next contention winner.
    task automatic test_err_winner();
        logic [8:0] exp;
        rr_if.req0 = 1; rr_if.we0 = 1; rr_if.addr0 = 32'h18; rr_if.wdata0 = 32'h1;
        rr_if.req1 = 1; rr_if.we1 = 1; rr_if.addr1 = 32'h1C; rr_if.wdata1 = 32'h2;
        tick();
        exp = 9'b1_1_0_0_1_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL err_winner_first: got %b required %b", rr_st(), exp);
        end
        rr_if.req0 = 0;
        tick();
        tick();
        exp = 9'b1_1_0_1_0_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL err_winner_second: got %b required %b", rr_st(), exp);
        end
        n_cmp++;
        if ({rr_if.data_address, rr_if.write_data} !== {32'h1C, 32'h2}) begin
            n_err++; $display("FAIL err_winner_bus: got %h/%h required 1c/2", rr_if.data_address, rr_if.write_data);
        end
        rr_if.req1 = 0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        logic [8:0] exp;
        rr_if.req0 = 1; rr_if.we0 = 0; rr_if.addr0 = 32'h14;
        tick();
        rr_if.req0 = 0;
        tick();
        exp = 9'b1_0_0_0_0_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL midread_resp: got %b required %b", rr_st(), exp);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (rr_st() !== 9'b0) begin
            n_err++; $display("FAIL midread_reset: got %b required 000000000", rr_st());
        end
        n_cmp++;
        if ({rr_if.rdata0, rr_if.rdata1} !== 64'h0) begin
            n_err++; $display("FAIL midread_rdata: got %h/%h required 0/0", rr_if.rdata0, rr_if.rdata1);
        end
        tick();
        n_cmp++;
        if (rr_st() !== 9'b0) begin
            n_err++; $display("FAIL midread_after: got %b required 000000000", rr_st());
        end
    endtask

    task automatic test_reset_req();
        logic [8:0] exp;
        rst = 1'b1;
        rr_if.req0 = 1; rr_if.we0 = 1; rr_if.addr0 = 32'h20; rr_if.wdata0 = 32'h9;
        tick();
        rst = 1'b0;
        n_cmp++;
        if (rr_st() !== 9'b0) begin
            n_err++; $display("FAIL reset_req_held: got %b required 000000000", rr_st());
        end
        tick();
        exp = 9'b1_1_0_0_1_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL reset_req_grant: got %b required %b", rr_st(), exp);
        end
        rr_if.req0 = 0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [8:0] exp;
        rr_if.req0 = 1; rr_if.we0 = 1; rr_if.addr0 = 32'h20; rr_if.wdata0 = 32'h9;
        tick();
        exp = 9'b1_1_0_0_1_0_0_0_0;
        n_cmp++;
        if (rr_st() !== exp) begin
            n_err++; $display("FAIL b2b_first: got %b required %b", rr_st(), exp);
        end
        rr_if.addr0 = 32'h24; rr_if.wdata0 = 32'hB;
        tick();
        n_cmp++;
        if (rr_st() !== 9'b0) begin
            n_err++; $display("FAIL b2b_gap: got %b required 000000000", rr_st());
        end
        tick();
        n_cmp++;
        if ({rr_st(), rr_if.data_address, rr_if.write_data} !== {exp, 32'h24, 32'hB}) begin
            n_err++; $display("FAIL b2b_second: got %b %h/%h required %b 24/b", rr_st(),
                              rr_if.data_address, rr_if.write_data, exp);
        end
        rr_if.req0 = 0;
        tick();
        rr_if.req0 = 1; rr_if.we0 = 0; rr_if.addr0 = 32'h24;
        tick();
        rr_if.req0 = 0;
        tick();
        tick();
        exp = 9'b0_0_0_0_0_0_0_0_1;
        n_cmp++;
        if ({rr_st(), rr_if.rdata0} !== {exp, 32'hB}) begin
            n_err++; $display("FAIL b2b_readback: got %b %h required %b b", rr_st(), rr_if.rdata0, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        idle_inputs();
        rr_if.read_data = '0;
        test_reset();
        test_write();
        test_read();
        test_contention();
        test_misaligned();
        test_err_winner();
        test_reset_mid_read();
        test_reset_req();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority with port 0 (CPU) always winning.
REQ-002 Parameter: ADDR_W, default 32, width of all address ports.
REQ-003 Parameter: DATA_W, default 32, width of all data ports.
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Ports: req0/req1  input  1 each  access request from port 0 (CPU) and port 1 (loader/debug).
REQ-007 Ports: we0/we1  input  1 each  1 = write, 0 = read.
REQ-008 Ports: addr0/addr1  input  ADDR_W each  byte address.
REQ-009 Ports: wdata0/wdata1  input  DATA_W each  write data.
REQ-010 Ports: gnt0/gnt1  output  1 each  one-cycle grant pulse; request accepted and issued.
REQ-011 Ports: rdata0/rdata1  output  DATA_W each  registered read data.
REQ-012 Ports: rvalid0/rvalid1  output  1 each  one-cycle pulse; rdataN valid.
REQ-013 Ports: err0/err1  output  1 each  one-cycle pulse; misaligned request rejected.
REQ-014 Ports: data_address (ADDR_W), write_data (DATA_W), MemRead (1), MemWrite (1)  output  drive the data memory.
REQ-015 Port: read_data  input  DATA_W  data memory output; valid the cycle after MemRead is high.
REQ-016 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-017 FSM states SHALL be IDLE, ISSUE, RESP, ERR; encoding free.
REQ-018 In IDLE, requests SHALL be sampled; if any reqN high, the winner's we/addr/wdata and port ID SHALL be latched at the edge and state SHALL go to ISSUE (ERR if latched addr[1:0] != 0).
REQ-019 Only one request SHALL be latched per IDLE cycle; the loser keeps req high and is re-evaluated in the next IDLE cycle.
REQ-020 RR_EN=1, both requesting: grant SHALL go to the port that is not last_winner; RR_EN=0: port 0 SHALL win.
REQ-021 last_winner SHALL update on every latch, including ERR latches.
REQ-022 In ISSUE: gntN of latched port = 1; data_address = latched addr; write_data = latched wdata; MemWrite = latched we; MemRead = !latched we.
REQ-023 MemRead/MemWrite SHALL be 0 in every state other than ISSUE; data_address/write_data SHALL hold the last latched values.
REQ-024 ISSUE -> IDLE for writes; ISSUE -> RESP for reads.
REQ-025 In RESP, read_data SHALL be registered into rdataN of the latched port at the edge leaving RESP; rvalidN SHALL be high for exactly the following cycle; state -> IDLE.
REQ-026 The non-selected port's rdata SHALL hold its previous value.
REQ-027 In ERR: gntN and errN of latched port = 1 for one cycle, no memory strobe, no rvalid; ERR -> IDLE.
REQ-028 Latency from req sampled in IDLE (edge E0): gnt in cycle after E0; read rvalid two cycles after E0; minimum spacing between issued accesses: 2 cycles (write), 3 cycles (read).
REQ-029 Requesters SHALL hold req/we/addr/wdata stable until gnt and deassert req at the edge ending the gnt cycle unless issuing a back-to-back request.
REQ-030 gnt0 and gnt1 SHALL never be high together; same for rvalid and err pairs.

Reset
REQ-031 On rst=1 at a rising edge: state = IDLE, last_winner = 1, gnt/rvalid/err/MemRead/MemWrite/busy = 0, rdata0/rdata1 = 0, data_address = 0, write_data = 0.
REQ-032 rst asserted in ISSUE or RESP SHALL abort the access: no rvalid, no err, no further memory strobe.
REQ-033 reqN high during the rst cycle SHALL NOT be latched; it is sampled in the first IDLE cycle after rst deasserts.

Verification
REQ-034 Write: req0=1, we0=1, addr0=0x10, wdata0=0x4 -> next cycle gnt0=1, MemWrite=1, data_address=0x10, write_data=0x4; busy=0 one cycle later.
REQ-035 Read: memory word 0x10 = 0x4; req1=1, we1=0, addr1=0x10 -> gnt1 cycle +1, MemRead=1 cycle +1, rvalid1=1 with rdata1=0x4 at cycle +3, rvalid0=0 throughout.
REQ-036 Contention, RR_EN=1, both reqs held high for reads after reset -> order port 0, port 1, port 0; RR_EN=0 -> port 0 only while req0 is held.
REQ-037 Misaligned: req0=1, addr0=0x6 -> gnt0=1 and err0=1 same cycle, MemRead=MemWrite=0, no rvalid0.
REQ-038 Reset mid-read: rst=1 during RESP -> next cycle state IDLE, rvalid0=rvalid1=0, rdata0=rdata1=0, MemRead=0.
